gate_vector_sequencer: RTL

- Sequential stimulus/capture stage that sits directly beside the 4-input gate block (q = (a&b)^(c&d)).
- Drives that block's a, b, c, d inputs through up to 16 vectors, holds each vector for a programmable dwell time, then samples the returned q.
- Records one result bit per vector and a count of ones, so the gate can be exercised in-system without a hand-written stimulus list.

---
 rtl/gate_vector_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/gate_vector_sequencer.sv
// Stimulus/capture sequencer for the 4-input gate q = (a&b)^(c&d): steps through
// NUM_VEC vectors, holds each for DWELL cycles, samples q_in once per vector. Optional macro: SEQ_GRAY_EN.
module gate_vector_sequencer #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned NUM_VEC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        q_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  vec_idx,
  output logic [4:0]  ones_cnt,
  output logic [15:0] result_vec
);

  // Handshake: start is a level request, accepted on a rising clk edge only in IDLE
  // or DONE; busy is high for the whole run; done stays high until the next accepted start.
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] IDX_LAST   = 4'(NUM_VEC - 1);

  state_t      state_q, state_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  vec_q, vec_d;
  logic [4:0]  ones_q, ones_d;
  logic [15:0] res_q, res_d;
  logic        last_dwell;

  function automatic logic [3:0] vector_of(input logic [3:0] i);
`ifdef SEQ_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign last_dwell = (dwell_q == DWELL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      ones_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      ones_q  <= ones_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    ones_d  = ones_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          dwell_d = '0;
          idx_d   = '0;
          vec_d   = vector_of(4'd0);
          ones_d  = '0;
          res_d   = '0;
        end
      end
      DRIVE: begin
        if (last_dwell) begin
          // Only the last dwell cycle is sampled so the gate has settled.
          dwell_d        = '0;
          res_d[vec_q]   = q_in;
          ones_d         = ones_q + {4'd0, q_in};
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            vec_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = vector_of(idx_q + 4'd1);
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = (state_q == DRIVE);
  assign done         = (state_q == DONE);
  assign vec_idx      = idx_q;
  assign ones_cnt     = ones_q;
  assign result_vec   = res_q;

endmodule
